cache_mem_responder: RTL and testbench
======================================

// Module: cache_mem_responder
// PURPOSE
//  Memory-side responder of the caches_if protocol: accepts instruction (iREN) and
//  data (dREN/dWEN) requests from the cache block, arbitrates them onto the single
//  RAM port, and returns iwait/dwait/iload/dload. Sits between caches and RAM; one
//  outstanding RAM transaction at a time, with a timeout watchdog on the RAM handshake.
// PARAMETERS
//  TIMEOUT  255  max cycles in an access state before the access is aborted with err
// PORTS
//  CLK       in   1   clock, rising edge
//  RST       in   1   synchronous reset, active-high
//  iREN      in   1   instruction read request (level, held until iwait low)
//  iaddr     in   32  instruction byte address
//  iwait     out  1   low for exactly one cycle when an instruction access completes
//  iload     out  32  instruction read data, registered, valid while iwait low
//  dREN      in   1   data read request (level)
//  dWEN      in   1   data write request (level); write wins if dREN also high
//  daddr     in   32  data byte address
//  dstore    in   32  data write value
//  dwait     out  1   low for exactly one cycle when a data access completes
//  dload     out  32  data read data, registered; 0 after a write
//  ramREN    out  1   RAM read enable
//  ramWEN    out  1   RAM write enable
//  ramaddr   out  32  RAM address (latched request address)
//  ramstore  out  32  RAM write data (latched dstore)
//  ramload   in   32  RAM read data, valid when ramstate==ACCESS
//  ramstate  in   2   FREE=0 BUSY=1 ACCESS=2 ERROR=3
//  err       out  1   one-cycle pulse with the wait-low cycle of a failed access
// BEHAVIOUR
//  - Reset (sync, RST=1): state IDLE; iwait=dwait=1; iload=dload=0; ramREN=ramWEN=0;
//    ramaddr=ramstore=0; err=0; timeout counter 0; last-grant flag = I.
//  - FSM IDLE -> IACC|DACC -> DONE -> IDLE. Registered outputs only.
//  - IDLE: if dREN|dWEN grant D (else if iREN grant I); latch addr, dstore, op. Next cycle
//    enter IACC/DACC. Nothing pending: stay IDLE, ram enables 0.
//  - IACC/DACC: ramREN (or ramWEN) =1, ramaddr/ramstore from latches; request-side
//    address/data changes ignored. Counter increments each cycle.
//    ramstate==ACCESS: capture ramload (0 for writes) -> DONE.
//    ramstate==ERROR or counter==TIMEOUT-1 without ACCESS: load 0, set err -> DONE.
//  - DONE (1 cycle): granted side's wait=0, load reg valid, err as set; ram enables 0;
//    counter cleared; -> IDLE. Min latency: request sampled cycle 0, RAM driven cycle 1,
//    ACCESS in cycle 1 -> wait low cycle 2. Back-to-back requests: 1 IDLE cycle between.
//  - Request withdrawn (granted REN/WEN low) during access: RAM access runs to
//    completion, DONE pulse (wait and err) suppressed; load reg still updated.
//  - Non-granted side keeps wait=1 and its load reg unchanged throughout.
//  - RST mid-access: next cycle IDLE, enables 0, no wait pulse.
//  - Counter width $clog2(TIMEOUT+1); saturates, never wraps.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: when I and D both pending in IDLE, grant the side NOT granted
//    last; last-grant flag updates on every grant. Single requester granted immediately.
//  ROUND_ROBIN_EN undefined: fixed D-over-I priority; I may starve under continuous D.
// TESTING
//  1 Reset: RST=1 2 cycles with iREN=dWEN=1 -> iwait=dwait=1, ramREN=ramWEN=0, loads 0, err 0.
//  2 I read: iREN=1 iaddr=0x100; ramstate BUSY 2 cycles then ACCESS, ramload=0xDEADBEEF ->
//    ramREN=1 ramaddr=0x100 from cycle 1; iwait=0 one cycle after ACCESS, iload=0xDEADBEEF.
//  3 Contention: iREN=1 and dWEN=1 daddr=0x200 dstore=0x12345678, last grant D ->
//    default: write first (ramWEN, ramstore=0x12345678, dwait pulse, dload=0) then I read;
//    ROUND_ROBIN_EN: I read first, then write.
//  4 Timeout/error: TIMEOUT=8, ramstate BUSY forever on dREN -> dwait=0 and err=1 in the
//    cycle after the 8th access cycle, dload=0; repeat with ramstate=ERROR -> err next cycle.
//  5 Withdraw: drop dREN 1 cycle into DACC -> access completes on RAM, dwait stays 1, err 0.
//  6 Reset mid-access: RST=1 in DACC -> next cycle IDLE, ramREN=0, no dwait pulse.

Source files
------------

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the caches_if protocol: arbitrates I/D requests onto one RAM port.
// Define ROUND_ROBIN_EN for alternating grants under contention; default is fixed D-over-I.
module cache_mem_responder #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] LastCount = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] MaxCount  = CW'(TIMEOUT);
   localparam logic [1:0] RamAccess = 2'd2;
   localparam logic [1:0] RamError  = 2'd3;

   typedef enum logic [1:0] {IDLE, IACC, DACC, DONE} stateType;

   stateType        state, nextState;
   logic [CW-1:0]   counter, nextCounter;
   logic            lastGrantD, nextLastGrantD;
   logic            opWrite, nextOpWrite;
   logic            withdrawn, nextWithdrawn;
   logic            nextIwait, nextDwait, nextErr;
   logic [31:0]     nextIload, nextDload;
   logic            nextRamREN, nextRamWEN;
   logic [31:0]     nextRamaddr, nextRamstore;
   logic            dReq, grantD, reqHeld, accessDone, accessFail;
   logic [31:0]     loadValue;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         counter    <= '0;
         lastGrantD <= 1'b0;
         opWrite    <= 1'b0;
         withdrawn  <= 1'b0;
         iwait      <= 1'b1;
         dwait      <= 1'b1;
         iload      <= '0;
         dload      <= '0;
         ramREN     <= 1'b0;
         ramWEN     <= 1'b0;
         ramaddr    <= '0;
         ramstore   <= '0;
         err        <= 1'b0;
      end else begin
         state      <= nextState;
         counter    <= nextCounter;
         lastGrantD <= nextLastGrantD;
         opWrite    <= nextOpWrite;
         withdrawn  <= nextWithdrawn;
         iwait      <= nextIwait;
         dwait      <= nextDwait;
         iload      <= nextIload;
         dload      <= nextDload;
         ramREN     <= nextRamREN;
         ramWEN     <= nextRamWEN;
         ramaddr    <= nextRamaddr;
         ramstore   <= nextRamstore;
         err        <= nextErr;
      end
   end

   // Every output is registered, so this block computes next values for all of them.
   always_comb begin
      nextState      = state;
      nextCounter    = counter;
      nextLastGrantD = lastGrantD;
      nextOpWrite    = opWrite;
      nextWithdrawn  = withdrawn;
      nextIwait      = 1'b1;
      nextDwait      = 1'b1;
      nextErr        = 1'b0;
      nextIload      = iload;
      nextDload      = dload;
      nextRamREN     = ramREN;
      nextRamWEN     = ramWEN;
      nextRamaddr    = ramaddr;
      nextRamstore   = ramstore;
      dReq           = dREN | dWEN;
      grantD         = 1'b0;
      reqHeld        = 1'b0;
      accessDone     = 1'b0;
      accessFail     = 1'b0;
      loadValue      = '0;

      case (state)
         IDLE: begin
            nextRamREN    = 1'b0;
            nextRamWEN    = 1'b0;
            nextCounter   = '0;
            nextWithdrawn = 1'b0;
`ifdef ROUND_ROBIN_EN
            grantD = dReq && !(iREN && lastGrantD);
`else
            grantD = dReq;
`endif
            if (grantD) begin
               nextState      = DACC;
               nextLastGrantD = 1'b1;
               nextOpWrite    = dWEN;
               nextRamaddr    = daddr;
               nextRamstore   = dstore;
               nextRamWEN     = dWEN;
               nextRamREN     = ~dWEN;
            end else if (iREN) begin
               nextState      = IACC;
               nextLastGrantD = 1'b0;
               nextOpWrite    = 1'b0;
               nextRamaddr    = iaddr;
               nextRamREN     = 1'b1;
            end
         end

         IACC, DACC: begin
            // A withdrawn request still finishes on the RAM but gets no completion pulse.
            reqHeld       = (state == DACC) ? dReq : iREN;
            nextWithdrawn = withdrawn | ~reqHeld;
            if (counter != MaxCount) begin
               nextCounter = counter + CW'(1);
            end
            if (ramstate == RamAccess) begin
               accessDone = 1'b1;
               loadValue  = opWrite ? 32'h0 : ramload;
            end else if ((ramstate == RamError) || (counter == LastCount)) begin
               accessDone = 1'b1;
               accessFail = 1'b1;
            end
            if (accessDone) begin
               nextState  = DONE;
               nextRamREN = 1'b0;
               nextRamWEN = 1'b0;
               if (state == DACC) begin
                  nextDload = loadValue;
               end else begin
                  nextIload = loadValue;
               end
               if (!nextWithdrawn) begin
                  if (state == DACC) begin
                     nextDwait = 1'b0;
                  end else begin
                     nextIwait = 1'b0;
                  end
                  nextErr = accessFail;
               end
            end
         end

         DONE: begin
            nextState   = IDLE;
            nextCounter = '0;
            nextRamREN  = 1'b0;
            nextRamWEN  = 1'b0;
         end

         default: begin
            nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed self-checking bench for cache_mem_responder, built with TIMEOUT=8.
module tb_cache_mem_responder;

   localparam logic [1:0] RamFree   = 2'd0;
   localparam logic [1:0] RamBusy   = 2'd1;
   localparam logic [1:0] RamAccess = 2'd2;
   localparam logic [1:0] RamError  = 2'd3;

   logic        CLK = 1'b0;
   logic        RST;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic [1:0]  ramstate;
   logic        err;

   int compareCount = 0;
   int failCount    = 0;

   cache_mem_responder #(.TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate), .err(err)
   );

   always #5 CLK = ~CLK;

   task automatic nextCycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic applyStimulus(input logic iRenV, input logic [31:0] iAddrV,
                                input logic dRenV, input logic dWenV,
                                input logic [31:0] dAddrV, input logic [31:0] dStoreV,
                                input logic [1:0] ramStateV, input logic [31:0] ramLoadV);
      iREN     = iRenV;
      iaddr    = iAddrV;
      dREN     = dRenV;
      dWEN     = dWenV;
      daddr    = dAddrV;
      dstore   = dStoreV;
      ramstate = ramStateV;
      ramload  = ramLoadV;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset held with requests asserted
      RST = 1'b1;
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      nextCycle();
      checkOutput("rst_iwait",  32'(iwait),  32'h1);
      checkOutput("rst_dwait",  32'(dwait),  32'h1);
      checkOutput("rst_ramREN", 32'(ramREN), 32'h0);
      checkOutput("rst_ramWEN", 32'(ramWEN), 32'h0);
      checkOutput("rst_iload",  iload,       32'h0);
      checkOutput("rst_dload",  dload,       32'h0);
      checkOutput("rst_err",    32'(err),    32'h0);

      // Instruction read, two BUSY cycles then ACCESS
      RST = 1'b0;
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, RamBusy, 32'h0);
      nextCycle();
      checkOutput("ird_ramREN_c1",  32'(ramREN), 32'h1);
      checkOutput("ird_ramaddr_c1", ramaddr,     32'h100);
      checkOutput("ird_iwait_c1",   32'(iwait),  32'h1);
      nextCycle();
      checkOutput("ird_ramREN_c2",  32'(ramREN), 32'h1);
      checkOutput("ird_iwait_c2",   32'(iwait),  32'h1);
      applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, RamAccess, 32'hDEADBEEF);
      nextCycle();
      checkOutput("ird_iwait_done", 32'(iwait),  32'h0);
      checkOutput("ird_iload",      iload,       32'hDEADBEEF);
      checkOutput("ird_ramREN_off", 32'(ramREN), 32'h0);
      checkOutput("ird_err",        32'(err),    32'h0);
      checkOutput("ird_dwait",      32'(dwait),  32'h1);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("ird_iwait_back", 32'(iwait), 32'h1);
      checkOutput("ird_iload_hold", iload,      32'hDEADBEEF);

      // Data read timing out after 8 BUSY access cycles
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, RamBusy, 32'hAAAA5555);
      nextCycle();
      checkOutput("tmo_ramREN_c1",  32'(ramREN), 32'h1);
      checkOutput("tmo_ramaddr",    ramaddr,     32'h300);
      repeat (7) nextCycle();
      checkOutput("tmo_dwait_c8",   32'(dwait),  32'h1);
      checkOutput("tmo_ramREN_c8",  32'(ramREN), 32'h1);
      checkOutput("tmo_err_c8",     32'(err),    32'h0);
      nextCycle();
      checkOutput("tmo_dwait_done", 32'(dwait),  32'h0);
      checkOutput("tmo_err_done",   32'(err),    32'h1);
      checkOutput("tmo_dload",      dload,       32'h0);
      checkOutput("tmo_ramREN_off", 32'(ramREN), 32'h0);
      checkOutput("tmo_iwait",      32'(iwait),  32'h1);
      checkOutput("tmo_iload_hold", iload,       32'hDEADBEEF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("tmo_dwait_back", 32'(dwait), 32'h1);
      checkOutput("tmo_err_back",   32'(err),   32'h0);

      // Data read with RAM reporting ERROR immediately
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0, RamError, 32'h5555AAAA);
      nextCycle();
      checkOutput("rerr_ramREN",    32'(ramREN), 32'h1);
      nextCycle();
      checkOutput("rerr_dwait",     32'(dwait),  32'h0);
      checkOutput("rerr_err",       32'(err),    32'h1);
      checkOutput("rerr_dload",     dload,       32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("rerr_err_back",  32'(err),    32'h0);

      // Data read withdrawn one cycle into the access; address change ignored
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, RamBusy, 32'h13579BDF);
      nextCycle();
      checkOutput("wd_ramREN_c1",  32'(ramREN), 32'h1);
      checkOutput("wd_ramaddr_c1", ramaddr,     32'h400);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h999, 32'h0, RamBusy, 32'h13579BDF);
      nextCycle();
      checkOutput("wd_ramREN_c2",  32'(ramREN), 32'h1);
      checkOutput("wd_ramaddr_c2", ramaddr,     32'h400);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h999, 32'h0, RamAccess, 32'h13579BDF);
      nextCycle();
      checkOutput("wd_dwait",      32'(dwait),  32'h1);
      checkOutput("wd_err",        32'(err),    32'h0);
      checkOutput("wd_ramREN_off", 32'(ramREN), 32'h0);
      checkOutput("wd_dload",      dload,       32'h13579BDF);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("wd_dwait_idle", 32'(dwait),  32'h1);
      checkOutput("wd_ramREN_idle", 32'(ramREN), 32'h0);

      // Contention: I read and D write together, last grant was D
      applyStimulus(1'b1, 32'h104, 1'b0, 1'b1, 32'h200, 32'h12345678, RamAccess, 32'hCAFEF00D);
`ifdef ROUND_ROBIN_EN
      nextCycle();
      checkOutput("rr_ramREN",    32'(ramREN), 32'h1);
      checkOutput("rr_ramWEN",    32'(ramWEN), 32'h0);
      checkOutput("rr_ramaddr_i", ramaddr,     32'h104);
      nextCycle();
      checkOutput("rr_iwait",     32'(iwait),  32'h0);
      checkOutput("rr_iload",     iload,       32'hCAFEF00D);
      checkOutput("rr_dwait_hold", 32'(dwait), 32'h1);
      checkOutput("rr_dload_hold", dload,      32'h13579BDF);
      applyStimulus(1'b0, 32'h104, 1'b0, 1'b1, 32'h200, 32'h12345678, RamAccess, 32'hCAFEF00D);
      nextCycle();
      checkOutput("rr_gap_ramWEN", 32'(ramWEN), 32'h0);
      checkOutput("rr_gap_iwait",  32'(iwait),  32'h1);
      nextCycle();
      checkOutput("rr_ramWEN_d",   32'(ramWEN), 32'h1);
      checkOutput("rr_ramaddr_d",  ramaddr,     32'h200);
      checkOutput("rr_ramstore",   ramstore,    32'h12345678);
      nextCycle();
      checkOutput("rr_dwait",      32'(dwait),  32'h0);
      checkOutput("rr_dload",      dload,       32'h0);
      checkOutput("rr_err",        32'(err),    32'h0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("rr_dwait_back", 32'(dwait),  32'h1);
`else
      nextCycle();
      checkOutput("pri_ramWEN",    32'(ramWEN), 32'h1);
      checkOutput("pri_ramREN",    32'(ramREN), 32'h0);
      checkOutput("pri_ramaddr_d", ramaddr,     32'h200);
      checkOutput("pri_ramstore",  ramstore,    32'h12345678);
      nextCycle();
      checkOutput("pri_dwait",     32'(dwait),  32'h0);
      checkOutput("pri_dload",     dload,       32'h0);
      checkOutput("pri_iwait_hold", 32'(iwait), 32'h1);
      checkOutput("pri_iload_hold", iload,      32'hDEADBEEF);
      applyStimulus(1'b1, 32'h104, 1'b0, 1'b0, 32'h200, 32'h12345678, RamAccess, 32'hCAFEF00D);
      nextCycle();
      checkOutput("pri_gap_ramREN", 32'(ramREN), 32'h0);
      checkOutput("pri_gap_ramWEN", 32'(ramWEN), 32'h0);
      checkOutput("pri_gap_dwait",  32'(dwait),  32'h1);
      nextCycle();
      checkOutput("pri_ramREN_i",  32'(ramREN), 32'h1);
      checkOutput("pri_ramaddr_i", ramaddr,     32'h104);
      nextCycle();
      checkOutput("pri_iwait",     32'(iwait),  32'h0);
      checkOutput("pri_iload",     iload,       32'hCAFEF00D);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamFree, 32'h0);
      nextCycle();
      checkOutput("pri_iwait_back", 32'(iwait), 32'h1);
`endif

      // Reset asserted in the middle of a data access
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, RamBusy, 32'h0);
      nextCycle();
      checkOutput("mrst_ramREN_acc", 32'(ramREN), 32'h1);
      RST = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RamBusy, 32'h0);
      nextCycle();
      checkOutput("mrst_ramREN", 32'(ramREN), 32'h0);
      checkOutput("mrst_dwait",  32'(dwait),  32'h1);
      checkOutput("mrst_err",    32'(err),    32'h0);
      checkOutput("mrst_iload",  iload,       32'h0);
      checkOutput("mrst_ramaddr", ramaddr,    32'h0);
      RST = 1'b0;
      nextCycle();
      checkOutput("mrst_dwait_after",  32'(dwait),  32'h1);
      checkOutput("mrst_ramREN_after", 32'(ramREN), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
